// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the MEM-stage external SRAM controller.
package arm_mem_pkg;

    // Transfer sequencing: idle, low half-word, high half-word, completion.
    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    // External SRAM data bus width.
    localparam int SRAM_DATA_W = 16;

    // Byte address that maps onto SRAM word 0 unless overridden.
    localparam int BASE_ADDR_DEFAULT = 1024;

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state counter for one half-word phase: clears on phase entry,
// counts up while the phase is held, flags the final cycle of the phase.
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic last
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear has priority over increment.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_ctrl.sv
// MEM-stage data memory controller: splits a 32-bit access into two 16-bit
// SRAM accesses with programmable wait states, stalling the pipeline via ready.
module sram_ctrl
    import arm_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = BASE_ADDR_DEFAULT,
    parameter int SRAM_ADDR_W = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_we_n
);

    localparam int WIDX_W = SRAM_ADDR_W - 1;

    state_t            state_q, state_d;
    logic              op_write_q, op_write_d;
    logic [WIDX_W-1:0] widx_q, widx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       read_data_q, read_data_d;

    logic        req;
    logic [31:0] offset;
    logic        cnt_clear;
    logic        cnt_inc;
    logic        cnt_last;
    logic        unused_offset_bits;

    assign req    = mem_read | mem_write;
    assign offset = address - 32'(BASE_ADDR);

    // Byte-offset bits and wrapped-away upper bits do not reach the SRAM.
    assign unused_offset_bits = ^{offset[1:0], offset[31:SRAM_ADDR_W+1]};

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .clk  (clk),
        .rst  (rst),
        .clear(cnt_clear),
        .inc  (cnt_inc),
        .last (cnt_last)
    );

    // Next-state logic: phase sequencing, request latching and read capture.
    always_comb begin
        state_d     = state_q;
        op_write_d  = op_write_q;
        widx_d      = widx_q;
        wdata_d     = wdata_q;
        read_data_d = read_data_q;
        cnt_clear   = 1'b1;
        cnt_inc     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d    = LOW;
                    op_write_d = mem_write;
                    widx_d     = offset[SRAM_ADDR_W:2];
                    wdata_d    = write_data;
                end
            end
            LOW: begin
                if (cnt_last) begin
                    state_d = HIGH;
                    if (!op_write_q) begin
                        read_data_d[15:0] = sram_dq_in;
                    end
                end else begin
                    cnt_clear = 1'b0;
                    cnt_inc   = 1'b1;
                end
            end
            HIGH: begin
                if (cnt_last) begin
                    state_d = DONE;
                    if (!op_write_q) begin
                        read_data_d[31:16] = sram_dq_in;
                    end
                end else begin
                    cnt_clear = 1'b0;
                    cnt_inc   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state, operation type and loaded word, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_write_q  <= 1'b0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            op_write_q  <= op_write_d;
            read_data_q <= read_data_d;
        end
    end

    // Latched word index and store data for the transfer in flight.
    always_ff @(posedge clk) begin
        // NOTE: these datapath registers are left unreset; every bus use is gated by state, which is reset.
        widx_q  <= widx_d;
        wdata_q <= wdata_d;
    end

    // SRAM bus decode from registered state, counter and latched operation only.
    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state_q)
            LOW: begin
                sram_addr = {widx_q, 1'b0};
                if (op_write_q) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_q[15:0];
                    sram_we_n   = cnt_last;
                end
            end
            HIGH: begin
                sram_addr = {widx_q, 1'b1};
                if (op_write_q) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_q[31:16];
                    sram_we_n   = cnt_last;
                end
            end
            default: begin
                sram_addr = '0;
            end
        endcase
    end

    assign ready     = ((state_q == IDLE) && !req) || (state_q == DONE);
    assign read_data = read_data_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: per-cycle bus scoreboard on a WAIT_CYCLES=2
// instance backed by a small SRAM model, plus a WAIT_CYCLES=1 back-to-back read run.
module tb_sram_ctrl;

    localparam int W = 2;

    typedef struct packed {
        logic        ready;
        logic [17:0] addr;
        logic [15:0] dq;
        logic        oe;
        logic        we_n;
    } bus_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Instance under test with WAIT_CYCLES=2.
    logic        mem_read, mem_write;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;

    // Instance under test with WAIT_CYCLES=1.
    logic        mem_read1, mem_write1;
    logic [31:0] address1, write_data1, read_data1;
    logic        ready1;
    logic [17:0] sram_addr1;
    logic [15:0] sram_dq_out1, sram_dq_in1;
    logic        sram_dq_oe1, sram_we_n1;

    sram_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(1024), .SRAM_ADDR_W(18)) u_dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
    );

    sram_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(1024), .SRAM_ADDR_W(18)) u_dut1 (
        .clk(clk), .rst(rst), .mem_read(mem_read1), .mem_write(mem_write1),
        .address(address1), .write_data(write_data1), .read_data(read_data1),
        .ready(ready1), .sram_addr(sram_addr1), .sram_dq_out(sram_dq_out1),
        .sram_dq_oe(sram_dq_oe1), .sram_dq_in(sram_dq_in1), .sram_we_n(sram_we_n1)
    );

    // SRAM model: asynchronous read, write captured on an edge while we_n is low.
    logic [15:0] sram [256];
    assign sram_dq_in = sram[sram_addr[7:0]];

    always @(posedge clk) begin
        if (rst) begin
            sram[10] <= 16'h1234;
            sram[11] <= 16'hABCD;
        end else if (!sram_we_n && sram_dq_oe) begin
            sram[sram_addr[7:0]] <= sram_dq_out;
        end
    end

    // Second instance reads a fixed pattern derived from the half-word address.
    assign sram_dq_in1 = 16'(sram_addr1) ^ 16'h5A00;

    // Bench-side golden memory contents and scoreboards.
    logic [15:0] gold [256];
    bus_t        exp_q [$];
    logic [31:0] rd_q [$];
    logic [31:0] exp_rd;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected bus behaviour of one access, cycle by cycle, from request to DONE.
    task automatic push_expect(input logic is_wr, input logic [16:0] widx, input logic [31:0] wd);
        bus_t e;
        e = bus_t'{ready: 1'b0, addr: 18'd0, dq: 16'd0, oe: 1'b0, we_n: 1'b1};
        exp_q.push_back(e);
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < W; c++) begin
                e.ready = 1'b0;
                e.addr  = {widx, (ph == 1)};
                e.dq    = (ph == 1) ? wd[31:16] : wd[15:0];
                e.oe    = is_wr;
                e.we_n  = is_wr ? (c == W - 1) : 1'b1;
                exp_q.push_back(e);
            end
        end
        e = bus_t'{ready: 1'b1, addr: 18'd0, dq: 16'd0, oe: 1'b0, we_n: 1'b1};
        exp_q.push_back(e);
    endtask

    // One access on the WAIT_CYCLES=2 instance; abort_at>0 asserts reset in that cycle.
    task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input int abort_at);
        logic [16:0] widx;
        logic [17:0] a0, a1;
        bus_t        e;
        logic        done;
        widx = 17'((addr - 32'd1024) >> 2);
        a0   = {widx, 1'b0};
        a1   = {widx, 1'b1};
        push_expect(wr, widx, wd);
        if (rd && !wr) begin
            exp_rd = {gold[a1[7:0]], gold[a0[7:0]]};
        end
        if (wr && abort_at == 0) begin
            gold[a0[7:0]] = wd[15:0];
            gold[a1[7:0]] = wd[31:16];
        end
        rd_q.push_back(exp_rd);

        @(negedge clk);
        mem_read   = rd;
        mem_write  = wr;
        address    = addr;
        write_data = wd;
        done       = 1'b0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            #1;
            e = exp_q.pop_front();
            check($sformatf("ready@%0h c%0d", addr, cyc), 32'(ready), 32'(e.ready));
            check($sformatf("sram_addr@%0h c%0d", addr, cyc), 32'(sram_addr), 32'(e.addr));
            check($sformatf("dq_oe@%0h c%0d", addr, cyc), 32'(sram_dq_oe), 32'(e.oe));
            check($sformatf("we_n@%0h c%0d", addr, cyc), 32'(sram_we_n), 32'(e.we_n));
            if (e.oe) begin
                check($sformatf("dq_out@%0h c%0d", addr, cyc), 32'(sram_dq_out), 32'(e.dq));
            end
            if (cyc == abort_at) begin
                rst       = 1'b1;
                mem_read  = 1'b0;
                mem_write = 1'b0;
                exp_q.delete();
                rd_q.delete();
                exp_rd = 32'd0;
                @(negedge clk);
                #1;
                check("abort ready", 32'(ready), 32'd1);
                check("abort we_n", 32'(sram_we_n), 32'd1);
                check("abort dq_oe", 32'(sram_dq_oe), 32'd0);
                check("abort sram_addr", 32'(sram_addr), 32'd0);
                check("abort read_data", read_data, 32'd0);
                rst  = 1'b0;
                done = 1'b1;
            end else if (e.ready) begin
                check($sformatf("read_data@%0h", addr), read_data, rd_q.pop_front());
                mem_read  = 1'b0;
                mem_write = 1'b0;
                done      = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int          done_cnt;
        logic [16:0] w1 [3];
        logic [15:0] lo, hi;

        rst         = 1'b1;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        address     = 32'd0;
        write_data  = 32'd0;
        mem_read1   = 1'b0;
        mem_write1  = 1'b0;
        address1    = 32'd0;
        write_data1 = 32'd0;
        exp_rd      = 32'd0;
        gold[10]    = 16'h1234;
        gold[11]    = 16'hABCD;

        repeat (3) @(negedge clk);
        #1;
        check("reset ready", 32'(ready), 32'd1);
        check("reset we_n", 32'(sram_we_n), 32'd1);
        check("reset dq_oe", 32'(sram_dq_oe), 32'd0);
        check("reset sram_addr", 32'(sram_addr), 32'd0);
        check("reset dq_out", 32'(sram_dq_out), 32'd0);
        check("reset read_data", read_data, 32'd0);
        check("reset read_data1", read_data1, 32'd0);
        rst = 1'b0;

        // Idle pass-through: no request keeps ready high.
        repeat (2) begin
            @(negedge clk);
            #1;
            check("idle ready", 32'(ready), 32'd1);
        end

        run_op(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 0);
        run_op(1'b1, 1'b0, 32'd1028, 32'd0, 0);
        run_op(1'b1, 1'b0, 32'd1044, 32'd0, 0);
        // Both request lines high: a write, read_data untouched.
        run_op(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 0);
        run_op(1'b1, 1'b0, 32'd1032, 32'd0, 0);
        // Reset during the first HIGH cycle of a write, then a normal read.
        run_op(1'b0, 1'b1, 32'd1036, 32'h55556666, 4);
        run_op(1'b1, 1'b0, 32'd1028, 32'd0, 0);

        // WAIT_CYCLES=1: three reads with mem_read held high through DONE.
        w1[0]    = 17'd3;
        w1[1]    = 17'd7;
        w1[2]    = 17'd100;
        done_cnt = 0;
        @(negedge clk);
        mem_read1 = 1'b1;
        address1  = 32'd1024 + 32'(w1[0]) * 32'd4;
        for (int k = 0; k < 3; k++) begin
            for (int c = 1; c <= 4; c++) begin
                #1;
                check($sformatf("w1 ready r%0d c%0d", k, c), 32'(ready1), 32'(c == 4));
                check($sformatf("w1 we_n r%0d c%0d", k, c), 32'(sram_we_n1), 32'd1);
                if (c == 2) begin
                    check($sformatf("w1 addr lo r%0d", k), 32'(sram_addr1), 32'({w1[k], 1'b0}));
                end
                if (c == 3) begin
                    check($sformatf("w1 addr hi r%0d", k), 32'(sram_addr1), 32'({w1[k], 1'b1}));
                end
                if (ready1) begin
                    done_cnt++;
                end
                if (c == 4) begin
                    lo = 16'({w1[k], 1'b0}) ^ 16'h5A00;
                    hi = 16'({w1[k], 1'b1}) ^ 16'h5A00;
                    check($sformatf("w1 read_data r%0d", k), read_data1, {hi, lo});
                    if (k < 2) begin
                        address1 = 32'd1024 + 32'(w1[k+1]) * 32'd4;
                    end
                end
                @(negedge clk);
            end
        end
        mem_read1 = 1'b0;
        check("w1 done pulses", 32'(done_cnt), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Multi-cycle controller that sequences a 32-bit word access from the MEM stage onto a 16-bit external SRAM. It replaces the single-cycle data memory behind the MEM stage. It splits each word into a low-half and a high-half SRAM access, inserting programmable wait states in each. While a transfer is in flight it holds `ready` low, which freezes the pipeline.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: cycles each half-word phase is held on the SRAM bus; must be ≥ 1.
- `BASE_ADDR`, default 1024: byte address mapped to SRAM word 0.
- `SRAM_ADDR_W`, default 18: SRAM half-word address width.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_read` in 1: read request from the MEM stage.
- `mem_write` in 1: write request from the MEM stage.
- `address` in 32: byte address (ALU result).
- `write_data` in 32: store data (Rm value).
- `read_data` out 32: loaded word.
- `ready` out 1: high when the MEM stage may advance.
- `sram_addr` out SRAM_ADDR_W: half-word address.
- `sram_dq_out` out 16: write data to the SRAM bus.
- `sram_dq_oe` out 1: bus drive enable.
- `sram_dq_in` in 16: read data from the SRAM bus.
- `sram_we_n` out 1: active-low write enable.

## Operation
- Word index: `widx = (address - BASE_ADDR) >> 2`. Width rule: truncate to SRAM_ADDR_W-1 bits; wrap-around is silent.
- Low phase: `sram_addr = {widx, 1'b0}`. High phase: `sram_addr = {widx, 1'b1}`.
- FSM states:
  - IDLE: if `mem_write`, go to LOW; else if `mem_read`, go to LOW; else stay in IDLE.
  - LOW: hold WAIT_CYCLES cycles, then go to HIGH.
  - HIGH: hold WAIT_CYCLES cycles, then go to DONE.
  - DONE: one cycle, then IDLE unconditionally.
- Wait-state counter: resets to 0 on each phase entry; a phase ends when the count equals WAIT_CYCLES-1.
- Operation type is latched at IDLE exit. If `mem_read` and `mem_write` are both high, the operation is a write.
- Write:
  - `sram_dq_oe = 1` in LOW and HIGH.
  - `sram_dq_out` = `write_data[15:0]` in LOW, `write_data[31:16]` in HIGH.
  - `sram_we_n = 0` in all phase cycles except the last cycle of each phase, which is the data-hold cycle.
- Read:
  - `sram_dq_oe = 0` and `sram_we_n = 1`.
  - `sram_dq_in` is latched into `read_data[15:0]` on the last LOW cycle and into `read_data[31:16]` on the last HIGH cycle.
- `ready` is combinational:
  - 1 in IDLE with no request, and 1 in DONE.
  - 0 in IDLE with a request, and 0 in LOW and HIGH.
- Requests arriving in DONE are ignored; the pipeline advances on that edge, and the next instruction's request is seen in IDLE.
- `address`, `write_data` and the request lines must be held stable by the requester until `ready` is high.
- `read_data` keeps its value until the next read overwrites it.

## Timing
- Reset values: state IDLE, counter 0, `read_data` 0, `sram_addr` 0, `sram_dq_out` 0, `sram_dq_oe` 0, `sram_we_n` 1. `ready` = 1 when no request is present.
- Latency: `ready` is low for 2·WAIT_CYCLES+1 cycles after a request appears in IDLE. The request completes on the DONE edge, 2·WAIT_CYCLES+2 cycles in total (6 cycles for WAIT_CYCLES=2).
- Reset mid-operation: next edge goes to IDLE with `sram_we_n=1` and `sram_dq_oe=0`. A partial write is abandoned (low half may be written); `read_data` is cleared.
- No request in IDLE: zero-cycle pass-through, `ready` stays 1.
- SRAM outputs are decoded from registered state, counter and latched operation only. The SRAM bus has no path from `address` that does not go through the FSM state.

## Structure
- Shared package `arm_mem_pkg` holds:
  - state enum {IDLE, LOW, HIGH, DONE};
  - `SRAM_DATA_W = 16`;
  - default `BASE_ADDR = 1024`.
- One sub-module, `sram_wait_counter`: load/clear, increment, and a `last` flag compared to WAIT_CYCLES-1.
- The top level contains the FSM, the operation latch, the `read_data` register and the bus decode.

## Test plan
All scenarios use WAIT_CYCLES=2 and BASE_ADDR=1024 unless noted.
- Reset → `ready=1`, `sram_we_n=1`, `sram_dq_oe=0`, `read_data=0`.
- Write 0xDEADBEEF to 1028:
  - `sram_addr` = 2 for 2 cycles with `dq_out` 0xBEEF, then 3 for 2 cycles with `dq_out` 0xDEAD;
  - `we_n` low in the first cycle of each phase;
  - `ready` low 5 cycles, high on cycle 6.
- Read from 1028 with the SRAM model holding {2:0xBEEF, 3:0xDEAD} → `read_data=0xDEADBEEF` when `ready` rises; `we_n` stays 1.
- `mem_read` and `mem_write` both high → write sequence performed, and `read_data` is unchanged.
- `rst` asserted during the HIGH phase of a write → IDLE next cycle, `we_n=1`, `ready=1`; the following read proceeds normally.
- WAIT_CYCLES=1, back-to-back reads held through DONE → each read takes 4 cycles, with exactly one DONE pulse per read.
